// File: rtl/clk_divider_multi_if.sv
// Handshake-free control/status bundle for the multi-channel clock divider.
// master drives run requests and divisors; slave returns waves, busy and strobes.
interface clk_divider_multi_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 24
) ();
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH*CNT_W-1:0] div;
  logic [NUM_CH-1:0]       clk_output;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       rise_stb;
  logic [NUM_CH-1:0]       fall_stb;

  modport master (
    output en, div,
    input  clk_output, busy, rise_stb, fall_stb
  );

  modport slave (
    input  en, div,
    output clk_output, busy, rise_stb, fall_stb
  );
endinterface

// File: rtl/clk_divider_multi.sv
// NUM_CH independent glitch-free programmable dividers off clk_12mhz.
// Ports: clk_12mhz, rst (async high), bus.slave: en/div in; clk_output,
// busy, rise_stb, fall_stb out. Strobes built only with CLK_DIV_STROBE_EN.
module clk_divider_multi #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 24
) (
  input logic                 clk_12mhz,
  input logic                 rst,
  clk_divider_multi_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [NUM_CH-1:0] out_v;
  logic [NUM_CH-1:0] busy_v;
  logic [NUM_CH-1:0] rise_v;
  logic [NUM_CH-1:0] fall_v;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dact_q, dact_d;
    logic             out_q, out_d;
    logic [CNT_W-1:0] div_i;
    logic [CNT_W-1:0] half;
    logic             div_ok;
    logic             wrap;

    assign div_i  = bus.div[i*CNT_W +: CNT_W];
    assign div_ok = div_i >= CNT_W'(2);
    assign half   = dact_q >> 1;
    assign wrap   = cnt_q == (dact_q - CNT_W'(1));

    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      dact_d = dact_q;
      out_d  = out_q;
      unique case (st_q)
        IDLE: begin
          out_d = 1'b0;
          if (bus.en[i] && div_ok) begin
            st_d   = RUN;
            dact_d = div_i;
            cnt_d  = '0;
            out_d  = 1'b1;
          end
        end
        RUN: begin
          if (wrap) begin
            cnt_d = '0;
            if (!bus.en[i]) begin
              // last period already finished low: stop without a runt
              st_d  = IDLE;
              out_d = 1'b0;
            end else begin
              // d_act >= 2 in RUN, so the new period always opens high
              out_d = 1'b1;
              if (div_ok) dact_d = div_i;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            out_d = cnt_d < half;
          end
        end
      endcase
    end

    always_ff @(posedge clk_12mhz or posedge rst) begin
      if (rst) begin
        st_q   <= IDLE;
        cnt_q  <= '0;
        dact_q <= '0;
        out_q  <= 1'b0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        dact_q <= dact_d;
        out_q  <= out_d;
      end
    end

    assign out_v[i]  = out_q;
    assign busy_v[i] = st_q == RUN;

`ifdef CLK_DIV_STROBE_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    always_comb begin
      rise_d = ~out_q & out_d;
      fall_d = out_q & ~out_d;
    end

    always_ff @(posedge clk_12mhz or posedge rst) begin
      if (rst) begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign rise_v[i] = rise_q;
    assign fall_v[i] = fall_q;
`else
    assign rise_v[i] = 1'b0;
    assign fall_v[i] = 1'b0;
`endif
  end

  assign bus.clk_output = out_v;
  assign bus.busy       = busy_v;
  assign bus.rise_stb   = rise_v;
  assign bus.fall_stb   = fall_v;

endmodule

// File: tb/tb_clk_divider_multi.sv
// Randomized bench for clk_divider_multi against a period-waveform model.
// Each started period is expanded into a queue of expected output samples.
module tb_clk_divider_multi;
  localparam int NCH = 2;
  localparam int CW  = 24;

  logic clk_12mhz = 1'b0;
  logic rst;

  clk_divider_multi_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

  clk_divider_multi #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clk_12mhz (clk_12mhz),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 clk_12mhz = ~clk_12mhz;

  int checks = 0;
  int errors = 0;

  typedef bit bq_t[$];
  bq_t         wave [NCH];
  int unsigned per  [NCH];
  bit          run  [NCH];
  bit          eo   [NCH];
  bit          eb   [NCH];
  bit          er   [NCH];
  bit          ef   [NCH];

  int unsigned dtab [8] = '{0, 1, 2, 3, 4, 5, 8, 12};

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      wave[i].delete();
      per[i] = 0;
      run[i] = 1'b0;
      eo[i]  = 1'b0;
      eb[i]  = 1'b0;
      er[i]  = 1'b0;
      ef[i]  = 1'b0;
    end
  endtask

  // Called once per clock edge with the inputs that were present at it.
  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      int unsigned d;
      bit e;
      bit prev;
      d    = bus.div[i*CW +: CW];
      e    = bus.en[i];
      prev = eo[i];
      if (wave[i].size() == 0) begin
        if (e && (run[i] || d >= 2)) begin
          if (d >= 2) per[i] = d;
          for (int j = 0; j < int'(per[i]); j++)
            wave[i].push_back(j < int'(per[i] / 2));
          run[i] = 1'b1;
        end else begin
          run[i] = 1'b0;
        end
      end
      eo[i] = (wave[i].size() != 0) ? wave[i].pop_front() : 1'b0;
      eb[i] = run[i];
`ifdef CLK_DIV_STROBE_EN
      er[i] = eo[i] & ~prev;
      ef[i] = ~eo[i] & prev;
`else
      er[i] = 1'b0;
      ef[i] = 1'b0;
`endif
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("out%0d", i),  32'(bus.clk_output[i]), 32'(eo[i]));
      check($sformatf("busy%0d", i), 32'(bus.busy[i]),       32'(eb[i]));
      check($sformatf("rise%0d", i), 32'(bus.rise_stb[i]),   32'(er[i]));
      check($sformatf("fall%0d", i), 32'(bus.fall_stb[i]),   32'(ef[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk_12mhz);
    if (!rst) model_step();
    #1;
    compare_all();
  endtask

  task automatic set_ch(int ch, bit e, int unsigned d);
    bus.en[ch]            = e;
    bus.div[ch*CW +: CW]  = CW'(d);
  endtask

  initial begin
    rst     = 1'b1;
    bus.en  = '0;
    bus.div = '0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;

    set_ch(0, 1'b1, 12);
    set_ch(1, 1'b1, 3);
    repeat (40) tick();

    set_ch(1, 1'b1, 2);
    repeat (12) tick();
    set_ch(1, 1'b0, 2);
    repeat (6) tick();
    set_ch(1, 1'b1, 1);
    repeat (8) tick();
    set_ch(1, 1'b1, 0);
    repeat (8) tick();

    repeat (3) tick();
    set_ch(0, 1'b1, 4);
    repeat (30) tick();

    set_ch(0, 1'b1, 8);
    repeat (13) tick();
    set_ch(0, 1'b0, 8);
    repeat (14) tick();

    set_ch(0, 1'b1, 6);
    set_ch(1, 1'b1, 4);
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    tick();
    rst = 1'b0;
    repeat (20) tick();

    repeat (3000) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(15) == 0)
          bus.div[i*CW +: CW] = CW'(dtab[$urandom_range(7)]);
        if ($urandom_range(39) == 0)
          bus.en[i] = ~bus.en[i];
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
